// File: rtl/core_types_pkg.sv
// Shared core types: fetch entry layout, NOP encoding and the fetch-queue head bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_types_pkg;

    localparam int CORE_XLEN = 32;

    // addi x0, x0, 0 -- what IF sees whenever the queue has nothing to offer
    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [CORE_XLEN-1:0] PC;
        logic [CORE_XLEN-1:0] inst;
    } fetch_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [CORE_XLEN-1:0] PC;
        logic [CORE_XLEN-1:0] instruction;
    } fetch_queue_out_t;

    // Head bundle presented to IF when no valid entry is available
    function automatic fetch_queue_out_t idle_out();
        fetch_queue_out_t o;
        o.valid       = 1'b0;
        o.PC          = '0;
        o.instruction = NOP_INST;
        return o;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between progMem and the IF stage register (FWFT head).
// Latency: pushed entry visible right after its push edge; head advances at the pop edge.
// Backpressure: push_ready = not full (registered count only, no full-queue bypass); hold blocks pop.
//
// Ports:
//   Clock, nReset           rising-edge clock, asynchronous active-low reset
//   flush                   branch redirect: empties queue at next edge, masks head and any push/pop
//   hold                    IF stall: blocks pop
//   push_valid/PC/inst      fetch-side offer; accepted when push_ready && !flush
//   push_ready              queue not full
//   valid_out, PC_out,
//   instruction_out         head entry; NOP / PC 0 when not valid
//   count                   occupancy 0..DEPTH
// XLEN must match core_types_pkg::CORE_XLEN, since storage uses the shared entry type.
module fetch_queue
    import core_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic                     flush,
    input  logic                     hold,
    input  logic                     push_valid,
    input  logic [XLEN-1:0]          push_PC,
    input  logic [XLEN-1:0]          push_inst,
    output logic                     push_ready,
    output logic                     valid_out,
    output logic [XLEN-1:0]          PC_out,
    output logic [XLEN-1:0]          instruction_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Storage is deliberately not reset; only pointers and count are.
    fetch_entry_t     mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             push_fire;
    logic             pop_fire;
    fetch_queue_out_t head;

    assign push_ready = (count != FULL_COUNT);
    assign valid_out  = (count != '0) && !flush;

    // Flush kills both sides of the handshake in its cycle.
    assign push_fire  = push_valid && push_ready && !flush;
    assign pop_fire   = valid_out && !hold;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_fire) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_fire) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (push_fire) begin
            mem[wptr] <= '{PC: push_PC, inst: push_inst};
        end
    end

    // First-word-fall-through head; substitute NOP whenever nothing valid is presented.
    always_comb begin
        head = idle_out();
        if (valid_out) begin
            head.valid       = 1'b1;
            head.PC          = mem[rptr].PC;
            head.instruction = mem[rptr].inst;
        end
    end

    assign PC_out          = head.PC;
    assign instruction_out = head.instruction;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic              Clock = 1'b0;
    logic              nReset;
    logic              flush;
    logic              hold;
    logic              push_valid;
    logic [XLEN-1:0]   push_PC;
    logic [XLEN-1:0]   push_inst;
    logic              push_ready;
    logic              valid_out;
    logic [XLEN-1:0]   PC_out;
    logic [XLEN-1:0]   instruction_out;
    logic [$clog2(DEPTH):0] count;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .Clock           (Clock),
        .nReset          (nReset),
        .flush           (flush),
        .hold            (hold),
        .push_valid      (push_valid),
        .push_PC         (push_PC),
        .push_inst       (push_inst),
        .push_ready      (push_ready),
        .valid_out       (valid_out),
        .PC_out          (PC_out),
        .instruction_out (instruction_out),
        .count           (count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        model_q[$];
    logic [31:0] dut_pops[$];
    int          checks = 0;
    int          errors = 0;
    bit          last_push_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare outputs mid-cycle, then advance the model at the rising edge.
    task automatic cycle(input string tag);
        bit          exp_valid;
        bit          do_push;
        bit          do_pop;
        @(negedge Clock);
        exp_valid = (model_q.size() != 0) && !flush;
        chk({tag, ".valid"}, 64'(valid_out), 64'(exp_valid));
        chk({tag, ".ready"}, 64'(push_ready), 64'(model_q.size() != DEPTH));
        chk({tag, ".count"}, 64'(count), 64'(model_q.size()));
        chk({tag, ".pc"},    64'(PC_out), exp_valid ? 64'(model_q[0].pc) : 64'd0);
        chk({tag, ".inst"},  64'(instruction_out),
            exp_valid ? 64'(model_q[0].inst) : 64'h13);
        do_pop  = exp_valid && !hold && nReset;
        do_push = push_valid && (model_q.size() < DEPTH) && !flush && nReset;
        if (do_pop) dut_pops.push_back(instruction_out);
        @(posedge Clock);
        if (!nReset || flush) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back('{pc: push_PC, inst: push_inst});
        end
        last_push_acc = do_push;
        #1;
    endtask

    task automatic drive(input bit pv, input logic [31:0] pc, input logic [31:0] inst,
                         input bit h, input bit f);
        push_valid = pv;
        push_PC    = pc;
        push_inst  = inst;
        hold       = h;
        flush      = f;
    endtask

    initial begin
        logic [31:0] pend_pc[$];
        logic [31:0] pend_inst[$];
        logic [31:0] exp_order[6];
        int          guard;
        bit          stuck;

        nReset = 1'b0;
        drive(0, 0, 0, 0, 0);

        // Reset then idle
        cycle("rst0");
        cycle("rst1");
        nReset = 1'b1;
        cycle("idle");

        // Fill to full with hold asserted
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'(4 * i), 32'hA0 + 32'(i), 1, 0);
            cycle("fill");
        end
        // Fifth push offered while full must not be accepted
        drive(1, 32'h10, 32'hA4, 1, 0);
        cycle("full");
        chk("full_reject", 64'(last_push_acc), 64'd0);
        chk("full_count", 64'(count), 64'd4);

        // Drain with wrap, pushing two more as slots free
        pend_pc   = '{32'h10, 32'h14};
        pend_inst = '{32'hA4, 32'hA5};
        dut_pops.delete();
        guard = 0;
        while ((pend_pc.size() != 0 || model_q.size() != 0) && guard < 30) begin
            if (pend_pc.size() != 0) drive(1, pend_pc[0], pend_inst[0], 0, 0);
            else                     drive(0, 0, 0, 0, 0);
            cycle("drain");
            if (last_push_acc) begin
                void'(pend_pc.pop_front());
                void'(pend_inst.pop_front());
            end
            guard++;
        end
        chk("drain_timeout", 64'(guard < 30), 64'd1);
        exp_order = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
        chk("drain_npops", 64'(dut_pops.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk("drain_order", (i < dut_pops.size()) ? 64'(dut_pops[i]) : 64'hDEAD,
                64'(exp_order[i]));
        end
        drive(0, 0, 0, 0, 0);
        cycle("empty");
        chk("empty_count", 64'(count), 64'd0);

        // Simultaneous push and pop at count=2
        drive(1, 32'h100, 32'hB0, 1, 0); cycle("sim_fill");
        drive(1, 32'h104, 32'hB1, 1, 0); cycle("sim_fill");
        drive(1, 32'h108, 32'hB2, 0, 0); cycle("sim_pp");
        drive(0, 0, 0, 1, 0);            cycle("sim_after");
        chk("sim_count", 64'(count), 64'd2);
        chk("sim_head", 64'(instruction_out), 64'hB1);

        // Flush mid-stream at count=3 with a push offered
        drive(1, 32'h10C, 32'hB3, 1, 0); cycle("fl_fill");
        chk("fl_count3", 64'(count), 64'd3);
        drive(1, 32'h200, 32'hC0, 0, 1); cycle("flush");
        drive(1, 32'h300, 32'hC1, 1, 0); cycle("post_flush");
        drive(0, 0, 0, 1, 0);            cycle("post_flush2");
        chk("flush_head", 64'(instruction_out), 64'hC1);
        chk("flush_pc", 64'(PC_out), 64'h300);

        // Asynchronous reset between edges at count=3
        drive(1, 32'h304, 32'hC2, 1, 0); cycle("ar_fill");
        drive(1, 32'h308, 32'hC3, 1, 0); cycle("ar_fill");
        drive(0, 0, 0, 1, 0);
        chk("ar_count3", 64'(count), 64'd3);
        #2 nReset = 1'b0;
        #1;
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_valid", 64'(valid_out), 64'd0);
        chk("ar_ready", 64'(push_ready), 64'd1);
        model_q.delete();
        drive(1, 32'h400, 32'hD0, 0, 0);
        cycle("ar_hold");
        nReset = 1'b1;
        drive(0, 0, 0, 0, 0);
        cycle("ar_release");

        // Randomized traffic; an offered push stays stable until accepted or flushed
        stuck = 0;
        for (int n = 0; n < 400; n++) begin
            if (!stuck) begin
                push_valid = ($urandom_range(0, 3) != 0);
                push_PC    = $urandom;
                push_inst  = $urandom;
            end
            hold  = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 15) == 0);
            cycle("rand");
            stuck = push_valid && !last_push_acc && !flush;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between `progMem` and the `IF` stage register. It stores up to DEPTH fetched {PC, instruction} pairs so the fetch side can run ahead while the pipeline is held. It presents the oldest pair to `IF` first-word-fall-through. It discards all contents on a branch flush.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2
- XLEN, 32, PC and instruction width

Ports:
- Clock  input  1  rising-edge clock
- nReset  input  1  asynchronous active-low reset
- flush  input  1  branch redirect from `branching`; empties the queue
- hold  input  1  IF stall from `branching`; blocks pop
- push_valid  input  1  fetch side offers an entry this cycle
- push_PC  input  XLEN  PC of the offered instruction
- push_inst  input  XLEN  offered instruction word
- push_ready  output  1  queue can accept a push (not full)
- valid_out  output  1  head entry is valid
- PC_out  output  XLEN  head PC, to `IF`
- instruction_out  output  XLEN  head instruction, to `IF`
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage is a DEPTH-entry array of `fetch_entry_t`, indexed by a write pointer and a read pointer.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is held in `count`.
- push fires when push_valid && push_ready && !flush. The entry is written at wptr, and wptr is incremented.
- pop fires when valid_out && !hold && !flush, and rptr is incremented.
- push_ready = (count != DEPTH). It does not depend on pop in the same cycle, so there is no full-queue bypass.
- valid_out = (count != 0) && !flush.
- When valid_out=1, PC_out and instruction_out are the head entry.
- When valid_out=0, instruction_out = NOP (0x00000013) and PC_out = 0.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Simultaneous push and pop is legal at any occupancy from 1 to DEPTH-1.
- When empty, push and pop cannot both fire, because valid_out=0.
- flush:
  - At the next edge, rptr, wptr and count go to 0.
  - Any push or pop offered in the flush cycle is discarded.
  - Stored entries are not cleared.
- hold while full: no pop; push_ready=0. The fetch side must keep push_valid, push_PC and push_inst stable until accepted.
- Array contents are not reset; only pointers and count are.

## Timing
- Reset (nReset=0, asynchronous): rptr=0, wptr=0, count=0.
  - Outputs during and after reset: valid_out=0, push_ready=1, instruction_out=NOP, PC_out=0.
- Push-to-visible latency: an entry pushed at edge N appears on PC_out/instruction_out after edge N, with no extra cycle when empty.
- Pop latency: the head advances at the edge where pop fires. The next entry is visible immediately after that edge.
- Output paths:
  - valid_out and the head outputs depend combinationally on flush and on the array/pointers.
  - push_ready depends only on registered count.
- flush with hold: flush has priority.
- flush with nReset low: reset has priority.
- Reset deasserted mid-stream: the queue starts empty, and any in-flight push is lost.
- Throughput: one push and one pop per cycle in steady state.

## Structure
- The `core_types_pkg` shared package holds:
  - `fetch_entry_t` typedef, packed {PC[XLEN-1:0], inst[XLEN-1:0]}
  - `NOP_INST` constant, 32'h00000013
  - `fetch_queue_out_t` struct {valid, PC, instruction}
- No sub-module. The storage array, the pointers and the count live in `fetch_queue`.
- In `core`, `IF` takes `instruction` and PC from this block.
- `IF` must treat valid_out=0 as an inserted NOP.

## Test plan
- Reset then idle: nReset=0 for 2 cycles, release.
  - Required: valid_out=0, instruction_out=0x00000013, PC_out=0, push_ready=1, count=0.
- Fill to full: push PC=0x00,0x04,0x08,0x0C with insts 0xA0..0xA3, hold=1 throughout.
  - Required: count=4, push_ready=0, head PC=0x00 inst=0xA0.
  - A 5th push offered while full is not accepted.
- Drain with wrap: continue from full, hold=0, push 0x10/0xA4 and 0x14/0xA5 as slots free.
  - Required: output order 0xA0..0xA5 with matching PCs, count back to 0, no duplicates or losses.
- Simultaneous push and pop at count=2: push_valid=1, hold=0.
  - Required: count stays 2, head advances by one.
- Flush mid-stream: count=3, assert flush for 1 cycle with push_valid=1.
  - Required: valid_out=0 during that cycle, count=0 after the edge, pushed entry discarded.
  - A push on the next cycle then appears as the head.
- Asynchronous reset mid-operation: drop nReset between edges with count=3.
  - Required: count=0 and valid_out=0 immediately, without waiting for Clock.
